// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed common-anode seven-segment digit scanner
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic                          load,
  output logic [3:0]                    digit_value,
  output logic                          digit_dp,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                 cnt;
  logic [IDX_W-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]       shadow_value;
  logic [NUM_DIGITS-1:0]            shadow_dp;
  logic [NUM_DIGITS-1:0][3:0]       stage_value;
  logic [NUM_DIGITS-1:0]            stage_dp;
  logic                             pend;
  logic                             slot_last;
  logic                             blank_digit;

  assign slot_last  = (cnt == CNT_LAST);
  assign frame_tick = slot_last && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      stage_value  <= '0;
      stage_dp     <= '0;
      pend         <= 1'b0;
    end else begin
      if (slot_last) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        stage_value <= value;
        stage_dp    <= dp_mask;
      end

      // Shadow only changes at the frame boundary so a frame never shows a torn value;
      // a load in the boundary cycle itself bypasses the staging registers.
      if (frame_tick) begin
        if (load) begin
          shadow_value <= value;
          shadow_dp    <= dp_mask;
        end else if (pend) begin
          shadow_value <= stage_value;
          shadow_dp    <= stage_dp;
        end
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  higher_zero;

  // A digit is a leading zero when it and everything above it is zero and it carries no DP.
  always_comb begin
    higher_zero = 1'b1;
    lz_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (shadow_value[i] == 4'h0);
      lz_blank[i] = higher_zero && !shadow_dp[i] && (i != 0);
    end
  end

  assign blank_digit = lz_blank[idx];
`else
  assign blank_digit = 1'b0;
`endif

  assign digit_value = shadow_value[idx];
  assign digit_dp    = shadow_dp[idx];
  assign digit_idx   = idx;

  always_comb begin
    anode = '1;
    if (!blank_digit && (cnt >= CNT_BLANK)) begin
      anode[idx] = 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner (4 digits, 8-cycle slots, 2 blank)
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        load;
  logic [3:0]  digit_value;
  logic        digit_dp;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic [3:0] an;
  } slot_t;

  slot_t sb[$];
  int    tests = 0;
  int    fails = 0;
  int    n;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .load(load),
    .digit_value(digit_value), .digit_dp(digit_dp), .anode(anode),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected slots of one frame, computed from the value and mask independently of the DUT.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    slot_t e[4];
    logic  hz;
    hz = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      e[i].nib = v[4*i +: 4];
      e[i].dp  = d[i];
      e[i].an  = ~(4'b0001 << i);
      hz = hz && (v[4*i +: 4] == 4'h0);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (i != 0 && hz && !d[i]) e[i].an = 4'b1111;
`endif
    end
    for (int i = 0; i < 4; i++) sb.push_back(e[i]);
  endtask

  task automatic wait_ft(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      cycles++;
    end while (!frame_tick && cycles < 200);
    if (!frame_tick) check("frame_tick_timeout", 32'd0, 32'd1);
  endtask

  // Called at the negedge of a frame_tick cycle; checks every cycle of the next frame and
  // optionally issues loads at (slot, cycle) points (-1 = none).
  task automatic check_frame(input string tag,
                             input int sa, input int ca, input logic [15:0] va, input logic [3:0] da,
                             input int sbx, input int cb, input logic [15:0] vb, input logic [3:0] db);
    slot_t e;
    for (int s = 0; s < ND; s++) begin
      if (sb.size() == 0) begin
        check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        e = '0;
      end else begin
        e = sb.pop_front();
      end
      for (int c = 0; c < RD; c++) begin
        @(negedge clk);
        check({tag, "_digit_value"}, 32'(digit_value), 32'(e.nib));
        check({tag, "_digit_dp"}, 32'(digit_dp), 32'(e.dp));
        check({tag, "_digit_idx"}, 32'(digit_idx), 32'(s));
        check({tag, "_anode"}, 32'(anode), (c < BC) ? 32'hF : 32'(e.an));
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'(s == ND - 1 && c == RD - 1));
        load = 1'b0;
        if (s == sa && c == ca) begin
          load = 1'b1; value = va; dp_mask = da;
        end else if (s == sbx && c == cb) begin
          load = 1'b1; value = vb; dp_mask = db;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0;

    // Reset held for three cycles, then released
    repeat (3) begin
      @(negedge clk);
      check("rst_anode", 32'(anode), 32'hF);
      check("rst_digit_value", 32'(digit_value), 32'h0);
      check("rst_digit_idx", 32'(digit_idx), 32'h0);
      check("rst_frame_tick", 32'(frame_tick), 32'h0);
    end
    rst = 1'b0;
    check("post_rst_anode_c0", 32'(anode), 32'hF);
    check("post_rst_digit_value", 32'(digit_value), 32'h0);
    @(negedge clk);
    check("post_rst_anode_c1", 32'(anode), 32'hF);
    @(negedge clk);
    check("post_rst_anode_c2", 32'(anode), 32'hE);

    // Scan order of 1234
    load = 1'b1; value = 16'h1234; dp_mask = 4'h0;
    wait_ft(n);
    check("first_frame_tick_cycle", 32'(n), 32'd29);
    push_frame(16'h1234, 4'h0);
    check_frame("scan1234", -1, 0, '0, '0, -1, 0, '0, '0);

    // Two mid-frame loads: display holds, last load wins at the boundary
    push_frame(16'h1234, 4'h0);
    check_frame("hold1234", 1, 3, 16'hABCD, 4'h0, 2, 3, 16'h5678, 4'h0);
    push_frame(16'h5678, 4'h0);
    check_frame("show5678", -1, 0, '0, '0, -1, 0, '0, '0);

    // Load coincident with frame_tick overrides pending 0000
    push_frame(16'h5678, 4'h0);
    check_frame("coincident", 1, 2, 16'h0000, 4'h0, 3, 7, 16'hFFFF, 4'h0);
    push_frame(16'hFFFF, 4'h0);
    check_frame("showFFFF", -1, 0, '0, '0, -1, 0, '0, '0);

    // Reset in slot 2 with a pending load
    @(negedge clk);
    load = 1'b1; value = 16'h1111; dp_mask = 4'hF;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (digit_idx != 2'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_slot2", 32'(digit_idx), 32'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_digit_idx", 32'(digit_idx), 32'd0);
    check("midrst_anode", 32'(anode), 32'hF);
    check("midrst_digit_value", 32'(digit_value), 32'h0);
    check("midrst_digit_dp", 32'(digit_dp), 32'h0);
    check("midrst_frame_tick", 32'(frame_tick), 32'h0);
    wait_ft(n);
    check("midrst_frame_len", 32'(n), 32'd31);

    // Pending load discarded: zeros shown; then leading-zero case 0042 with DP on digit 2
    push_frame(16'h0000, 4'h0);
    check_frame("after_rst", 0, 3, 16'h0042, 4'b0100, -1, 0, '0, '0);
    push_frame(16'h0042, 4'b0100);
    check_frame("lzb0042", -1, 0, '0, '0, -1, 0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
